// File: rtl/wb_pkg.sv
// wb_pkg - shared types for the Wishbone RAM slave.
//   state_t  : slave FSM states (IDLE, BUSY, ACK)
//   WB_SEL_W : number of byte lanes on the 32-bit data bus
//   CNT_W    : width of the wait-state counter (WAIT_STATES is 0..7)
package wb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int WB_SEL_W = 4;
  localparam int CNT_W    = 3;
endpackage

// File: rtl/bram_sp_be.sv
// bram_sp_be - single-port RAM, 32-bit words, 4 byte-write enables,
// synchronous read. No reset on contents or output so block RAM infers.
//   i_clk   : clock
//   i_rd_en : load o_rdata from i_addr at the rising edge
//   i_wr_be : per-byte write enables (bit n -> wdata[8n+7:8n])
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data, holds until the next read
module bram_sp_be
  import wb_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                i_clk,
  input  logic                i_rd_en,
  input  logic [WB_SEL_W-1:0] i_wr_be,
  input  logic [AW-1:0]       i_addr,
  input  logic [31:0]         i_wdata,
  output logic [31:0]         o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_q;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < WB_SEL_W; b++) begin
      if (i_wr_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_rd_en) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/wb_ram_slave.sv
// wb_ram_slave - Wishbone B4 pipelined slave in front of a byte-writable RAM.
// Accepts one request per WAIT_STATES+1 cycles; out-of-range accesses are
// acked with no write and zero read data.
//   clk_i, rst_i          : clock, async active-low reset
//   wb_adr_i / wb_dat_i   : byte address (bits [1:0] ignored) / write data
//   wb_we_i / wb_sel_i    : write strobe / byte enables
//   wb_stb_i / wb_cyc_i   : strobe / cycle valid
//   wb_dat_o              : read data (meaningful while wb_ack_o)
//   wb_ack_o / wb_stall_o : one-cycle ack / request not accepted
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic                wb_we_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic                wb_ack_o,
  output logic                wb_stall_o
);

  localparam int              AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WS = 3'(WAIT_STATES);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                r_ack;
  logic                r_stall;
  logic                r_zero;

  logic                w_accept;
  logic                w_in_range;
  logic [AW-1:0]       w_idx;
  logic                w_rd_en;
  logic [WB_SEL_W-1:0] w_wr_be;
  logic [31:0]         w_ram_q;
  logic [1:0]          w_unused_adr;

  assign w_unused_adr = wb_adr_i[1:0];

  // Decode: stall comes from a register, so accept has no loop through it.
  assign w_accept   = wb_cyc_i & wb_stb_i & ~r_stall;
  assign w_in_range = (wb_adr_i[31:AW+2] == ADDR_BASE[31:AW+2]);
  assign w_idx      = wb_adr_i[AW+1:2];
  assign w_rd_en    = w_accept & ~wb_we_i & w_in_range;
  assign w_wr_be    = (w_accept & wb_we_i & w_in_range) ? wb_sel_i : '0;

  bram_sp_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .i_clk   (clk_i),
    .i_rd_en (w_rd_en),
    .i_wr_be (w_wr_be),
    .i_addr  (w_idx),
    .i_wdata (wb_dat_i),
    .o_rdata (w_ram_q)
  );

  // rdata_q is the RAM output register qualified by r_zero: an out-of-range
  // access (or reset) forces zero, an in-range read takes the RAM word, and
  // an in-range write touches neither, so the last read data is held.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_zero <= 1'b1;
    end else if (w_accept) begin
      if (!w_in_range)   r_zero <= 1'b1;
      else if (!wb_we_i) r_zero <= 1'b0;
    end
  end

  assign wb_dat_o = r_zero ? '0 : w_ram_q;

  // Ack is a pure register: dropping cyc in BUSY suppresses the ack before it
  // is issued; an ack already on the bus cannot be withdrawn combinationally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_ack   <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACK: begin
          if (w_accept) begin
            if (WS == '0) begin
              state_q <= ACK;
              r_ack   <= 1'b1;
              r_stall <= 1'b0;
            end else begin
              state_q <= BUSY;
              cnt_q   <= WS;
              r_ack   <= 1'b0;
              r_stall <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            r_ack   <= 1'b0;
            r_stall <= 1'b0;
          end
        end
        BUSY: begin
          if (!wb_cyc_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_ack   <= 1'b0;
            r_stall <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == 3'd1) begin
              state_q <= ACK;
              r_ack   <= 1'b1;
              r_stall <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          r_ack   <= 1'b0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_stall_o = r_stall;

endmodule
